instr_decode_controller: RTL

//  Fetches 32-bit instructions from a 1-cycle-latency instruction ROM and decodes ADD/ADDI/NOP/HALT.

---
 rtl/instr_decode_controller.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/instr_decode_controller.sv
// Fetch/decode/dispatch controller for ADD, ADDI, NOP and HALT ahead of the FPU add controller.
// Optional per-dispatch watchdog enabled by defining ISSUE_TIMEOUT_EN.
module instr_decode_controller #(
  parameter logic [4:0] START_PC       = 5'd0,
  parameter int         RETIRE_W       = 16,
  parameter int         TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  output logic [4:0]          instr_addr,
  input  logic [31:0]         instr_data,
  output logic                add_start,
  output logic [1:0]          add_op_type,
  output logic [4:0]          add_pc,
  output logic [4:0]          add_rs1,
  output logic [4:0]          add_rs2,
  output logic [4:0]          add_rd,
  output logic [31:0]         add_imm,
  input  logic [4:0]          add_next_pc,
  input  logic                add_busy,
  input  logic                add_done,
  output logic                halted,
  output logic                illegal_instr,
  output logic                timeout_err,
  output logic [RETIRE_W-1:0] retired
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
    $error("TIMEOUT_CYCLES must be at least 1");
  end
  if (RETIRE_W < 1) begin : g_bad_rw
    $error("RETIRE_W must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_MEM_WAIT,
    S_DECODE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_HALT
  } state_t;

  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_ADDI = 6'h02;
  localparam logic [5:0] OP_HALT = 6'h3F;

  state_t              state_q, state_d;
  logic [4:0]          pc_q, pc_d;
  logic [31:0]         ir_q, ir_d;
  logic                start_q, start_d;
  logic [1:0]          op_q, op_d;
  logic [4:0]          apc_q, apc_d;
  logic [4:0]          rs1_q, rs1_d;
  logic [4:0]          rs2_q, rs2_d;
  logic [4:0]          rd_q, rd_d;
  logic [31:0]         imm_q, imm_d;
  logic                halted_q, halted_d;
  logic                ill_q, ill_d;
  logic [RETIRE_W-1:0] ret_q, ret_d;

  logic [5:0] opcode;
  logic       is_nop, is_add, is_addi, is_halt;
  logic       op_done;

  assign opcode  = ir_q[31:26];
  assign is_nop  = (opcode == OP_NOP);
  assign is_add  = (opcode == OP_ADD);
  assign is_addi = (opcode == OP_ADDI);
  assign is_halt = (opcode == OP_HALT);
  assign op_done = !add_busy && add_done;

`ifdef ISSUE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_err_q, tmo_err_d;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    start_d  = 1'b0;
    op_d     = op_q;
    apc_d    = apc_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    rd_d     = rd_q;
    imm_d    = imm_q;
    halted_d = halted_q;
    ill_d    = ill_q;
    ret_d    = ret_q;
`ifdef ISSUE_TIMEOUT_EN
    tmo_d     = tmo_q;
    tmo_err_d = tmo_err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        ir_d    = instr_data;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        unique case (1'b1)
          is_nop: begin
            pc_d    = pc_q + 5'd1;
            ret_d   = ret_q + RETIRE_W'(1);
            state_d = S_FETCH;
          end
          is_add, is_addi: begin
            op_d    = is_addi ? 2'd1 : 2'd0;
            apc_d   = pc_q;
            rd_d    = ir_q[25:21];
            rs1_d   = ir_q[20:16];
            rs2_d   = ir_q[15:11];
            imm_d   = {ir_q[15:0], 16'h0000};
            start_d = 1'b1;
            state_d = S_ISSUE;
          end
          is_halt: begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end
          default: begin
            halted_d = 1'b1;
            ill_d    = 1'b1;
            state_d  = S_HALT;
          end
        endcase
      end
      S_ISSUE: begin
`ifdef ISSUE_TIMEOUT_EN
        tmo_d = '0;
`endif
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        // A done level left over from the previous op is not an accept
        if (add_busy) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (op_done) begin
          pc_d    = add_next_pc;
          ret_d   = ret_q + RETIRE_W'(1);
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
`ifdef ISSUE_TIMEOUT_EN
    if ((state_q == S_WAIT_ACK) ||
        (state_q == S_WAIT_DONE && !op_done)) begin
      tmo_d = tmo_q + TW'(1);
      if (tmo_q == TMO_LAST) begin
        halted_d  = 1'b1;
        tmo_err_d = 1'b1;
        pc_d      = pc_q;
        state_d   = S_HALT;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= START_PC;
      ir_q     <= '0;
      start_q  <= 1'b0;
      op_q     <= '0;
      apc_q    <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      imm_q    <= '0;
      halted_q <= 1'b0;
      ill_q    <= 1'b0;
      ret_q    <= '0;
`ifdef ISSUE_TIMEOUT_EN
      tmo_q     <= '0;
      tmo_err_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      start_q  <= start_d;
      op_q     <= op_d;
      apc_q    <= apc_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rd_q     <= rd_d;
      imm_q    <= imm_d;
      halted_q <= halted_d;
      ill_q    <= ill_d;
      ret_q    <= ret_d;
`ifdef ISSUE_TIMEOUT_EN
      tmo_q     <= tmo_d;
      tmo_err_q <= tmo_err_d;
`endif
    end
  end

  assign instr_addr    = pc_q;
  assign add_start     = start_q;
  assign add_op_type   = op_q;
  assign add_pc        = apc_q;
  assign add_rs1       = rs1_q;
  assign add_rs2       = rs2_q;
  assign add_rd        = rd_q;
  assign add_imm       = imm_q;
  assign halted        = halted_q;
  assign illegal_instr = ill_q;
  assign retired       = ret_q;
`ifdef ISSUE_TIMEOUT_EN
  assign timeout_err   = tmo_err_q;
`else
  assign timeout_err   = 1'b0;
`endif

endmodule
